// File: rtl/uart_instr_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_instr_loader_if.sv
// Instruction-memory write port: single-cycle strobe with word address and data.
interface imem_wr_if #(
  parameter int ADDR_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;

  modport master (output we, wa, wd);
  modport slave  (input  we, wa, wd);
endinterface

// File: rtl/uart_instr_loader_rx_byte.sv
// 8N1 byte receiver: rxd synchroniser, 16x tick generator and receive FSM.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse,
  output logic       busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int DIV_W = $clog2(DIV + 1);

  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_sync_q, rxd_sync_d;
  logic             rxd_prev_q, rxd_prev_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick, start_edge;

  rx_state_t        state_q;
  logic [3:0]       tick_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_comb begin
    rxd_meta_d = rxd;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    tick       = (div_cnt_q == DIV_W'(DIV - 1));
    start_edge = (state_q == IDLE) && rxd_prev_q && !rxd_sync_q;
    // Realign the tick phase to each start edge so sampling stays mid-bit.
    div_cnt_d  = (start_edge || tick) ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      div_cnt_q  <= '0;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rxd_prev_q <= rxd_prev_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q    <= START;
            tick_cnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == 4'(MID_SAMPLE - 1)) begin
              tick_cnt_q <= '0;
              bit_idx_q  <= '0;
              // A start bit that is high again by mid-bit was only a glitch.
              state_q    <= rxd_sync_q ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              shift_q    <= {rxd_sync_q, shift_q[7:1]};
              bit_idx_q  <= bit_idx_q + 1'b1;
              if (bit_idx_q == 3'd7) state_q <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              if (rxd_sync_q) byte_valid_q <= 1'b1;
              else            frame_err_q  <= 1'b1;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_valid      = byte_valid_q;
  assign byte_data       = shift_q;
  assign frame_err_pulse = frame_err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: rtl/uart_instr_loader.sv
// Serial program loader: packs UART bytes big-endian into 32-bit instruction words.
// Optional partial-word timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_instr_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  imem_wr_if.master   imem,
  output logic        hold,
  output logic        loaded,
  output logic        frame_err
);

  logic       byte_valid, frame_err_pulse, busy;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .rxd             (rxd),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse),
    .busy            (busy)
  );

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              loaded_q, loaded_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_hit;

`ifdef LOADER_TIMEOUT_EN
  localparam int CPB   = OVERSAMPLE * calc_div(CLK_FREQ, BAUD);
  localparam int CPB_W = $clog2(CPB + 1);
  localparam int BIT_W = $clog2(TIMEOUT_BITS + 1);

  logic [CPB_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Bit-times are only counted while idle between bytes of a partial word.
  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    if (busy || byte_idx_q == 2'd0) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (clk_cnt_q == CPB_W'(CPB - 1)) begin
      clk_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    timeout_hit = (bit_cnt_q == BIT_W'(TIMEOUT_BITS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_bits;
  assign unused_timeout_bits = TIMEOUT_BITS;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    we_d        = 1'b0;
    wa_d        = wa_q + ADDR_W'(we_q);
    wd_d        = wd_q;
    loaded_d    = loaded_q;
    frame_err_d = frame_err_q;
    if (frame_err_pulse) begin
      byte_idx_d  = '0;
      frame_err_d = 1'b1;
    end else if (byte_valid) begin
      buf_d = {buf_q[15:0], byte_data};
      if (byte_idx_q == 2'd3) begin
        // wd only changes here, so it is stable through the we cycle.
        wd_d       = {buf_q, byte_data};
        we_d       = 1'b1;
        loaded_d   = 1'b1;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end else if (timeout_hit) begin
      byte_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx_q  <= '0;
      buf_q       <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      loaded_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      loaded_q    <= loaded_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign imem.we   = we_q;
  assign imem.wa   = wa_q;
  assign imem.wd   = wd_q;
  assign hold      = busy || (byte_idx_q != 2'd0);
  assign loaded    = loaded_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader at 160 clk per bit, ADDR_W=2.
module tb_uart_instr_loader;

  localparam int CPB = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic hold, loaded, frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wd_log[$];
  logic [31:0] wa_log[$];

  imem_wr_if #(.ADDR_W(2)) imem ();

  uart_instr_loader #(
    .CLK_FREQ     (1_600_000),
    .BAUD         (10_000),
    .ADDR_W       (2),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .imem      (imem),
    .hold      (hold),
    .loaded    (loaded),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem.we === 1'b1) begin
      wa_log.push_back(32'(imem.wa));
      wd_log.push_back(imem.wd);
      $display("write wa=%0d wd=0x%08h at %0t", imem.wa, imem.wd, $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(posedge clk);
    rxd = 1'b1;
    repeat (idle_bits * CPB) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1, 0);
    send_byte(w[23:16], 1'b1, 0);
    send_byte(w[15:8],  1'b1, 0);
    send_byte(w[7:0],   1'b1, 1);
  endtask

  task automatic do_reset();
    rxd = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    wd_log.delete();
    wa_log.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_we",        32'(imem.we),   32'd0);
    check("rst_wa",        32'(imem.wa),   32'd0);
    check("rst_wd",        imem.wd,        32'd0);
    check("rst_hold",      32'(hold),      32'd0);
    check("rst_loaded",    32'(loaded),    32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    do_reset();

    // Basic word
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    #1 check("t1_hold_partial", 32'(hold), 32'd1);
    send_byte(8'h56, 1'b1, 0);
    send_byte(8'h78, 1'b1, 1);
    #1;
    check("t1_count",  32'(wd_log.size()), 32'd1);
    check("t1_wa",     wa_log.size() > 0 ? wa_log[0] : 32'hDEAD, 32'd0);
    check("t1_wd",     wd_log.size() > 0 ? wd_log[0] : 32'hDEAD, 32'h12345678);
    check("t1_wa_after", 32'(imem.wa), 32'd1);
    check("t1_loaded", 32'(loaded), 32'd1);
    check("t1_hold",   32'(hold),   32'd0);

    // Start-bit glitch
    do_reset();
    rxd = 1'b0;
    repeat (30) @(posedge clk);
    rxd = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("t2_count",     32'(wd_log.size()), 32'd0);
    check("t2_frame_err", 32'(frame_err), 32'd0);
    check("t2_hold",      32'(hold), 32'd0);

    // Frame error discards partial word
    do_reset();
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hBB, 1'b0, 2);
    #1 check("t3_frame_err_early", 32'(frame_err), 32'd1);
    check("t3_hold_cleared", 32'(hold), 32'd0);
    send_word(32'h01020304);
    #1;
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_count", 32'(wd_log.size()), 32'd1);
    check("t3_wa", wa_log.size() > 0 ? wa_log[0] : 32'hDEAD, 32'd0);
    check("t3_wd", wd_log.size() > 0 ? wd_log[0] : 32'hDEAD, 32'h01020304);

    // Address wrap with ADDR_W=2
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'(i));
    #1;
    check("t4_count", 32'(wd_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_wa;
      exp_wa = (i == 4) ? 32'd0 : 32'(i);
      check($sformatf("t4_wa%0d", i), wa_log.size() > i ? wa_log[i] : 32'hDEAD, exp_wa);
    end
    check("t4_wd4", wd_log.size() > 4 ? wd_log[4] : 32'hDEAD, 32'h00000004);

    // Reset mid-word
    do_reset();
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("t5_hold_after_rst", 32'(hold), 32'd0);
    repeat (2) @(posedge clk);
    send_word(32'hCAFEBABE);
    #1;
    check("t5_count", 32'(wd_log.size()), 32'd1);
    check("t5_wa", wa_log.size() > 0 ? wa_log[0] : 32'hDEAD, 32'd0);
    check("t5_wd", wd_log.size() > 0 ? wd_log[0] : 32'hDEAD, 32'hCAFEBABE);

    // Long idle inside a partial word
    do_reset();
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 30);
    #1;
`ifdef LOADER_TIMEOUT_EN
    check("t6_hold_timeout", 32'(hold), 32'd0);
    send_word(32'h33445566);
    #1;
    check("t6_count", 32'(wd_log.size()), 32'd1);
    check("t6_wd", wd_log.size() > 0 ? wd_log[0] : 32'hDEAD, 32'h33445566);
`else
    check("t6_hold_persist", 32'(hold), 32'd1);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 1);
    #1;
    check("t6_count", 32'(wd_log.size()), 32'd1);
    check("t6_wd", wd_log.size() > 0 ? wd_log[0] : 32'hDEAD, 32'h11223344);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
# uart_instr_loader

Serial program loader that receives 8N1 UART bytes on the board's UART_RXD pin and writes the bytes into the processor's instruction memory as 32-bit words. It assembles four bytes into one word and issues a single-cycle write. It holds the processor (PC/register-file clock gating) while a load is in progress. Without it, instruction memory is read-only; this block is the writer side of that memory port.

## Interface
Parameters:
- CLK_FREQ, 50_000_000 — clk frequency in Hz
- BAUD, 115200 — serial bit rate
- ADDR_W, 8 — instruction-memory word-address width
- TIMEOUT_BITS, 64 — idle bit-times before a partial word is dropped (used only with LOADER_TIMEOUT_EN)

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  reset; synchronous, active-low
- rxd  in  1  asynchronous serial input; idle high
- we  out  1  instruction-memory write strobe; one-cycle pulse
- wa  out  ADDR_W  word address for the current write
- wd  out  32  write data
- hold  out  1  high while a partial word (1–3 bytes) is buffered or a byte is being received
- loaded  out  1  sticky; set after the first word is written
- frame_err  out  1  sticky; set on a bad stop bit

## Operation
- rxd passes through a 2-FF synchroniser before use. Its reset value is 1.
- The tick generator produces one-cycle pulses at 16×BAUD. Divisor = round(CLK_FREQ/(16·BAUD)); for 50 MHz / 115200 the divisor is 27. The counter restarts on each detected start edge.
- Receive FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - START: sample at tick 8. If the sample is high, the edge was a glitch: return to IDLE with no error. If low, go to DATA.
  - DATA: 8 bits, LSB first, each sampled at tick 16 after the previous sample. Go to STOP after bit 7.
  - STOP: sample at mid-bit. If high, the byte is valid. If low, set frame_err, discard the byte, and clear the partial word. Return to IDLE either way.
- Word assembly is big-endian. First byte → wd[31:24]; fourth byte → wd[7:0]. A 2-bit byte index is cleared on frame error, on timeout, and on reset.
- On the fourth valid byte:
  - we=1 for exactly one cycle, with wa/wd stable during that cycle.
  - wa increments in the cycle after we, wrapping from 2^ADDR_W−1 to 0.
  - loaded is set.
- hold = (FSM≠IDLE) OR (byte index≠0).
- Reset values: we=0, wa=0, wd=0, hold=0, loaded=0, frame_err=0, FSM=IDLE, byte index=0.
- A reset mid-byte or mid-word discards all partial data. No write is emitted.

## Timing
- rxd to internal sample: 2 clk of synchroniser latency.
- Stop-bit mid-sample of the 4th byte → we high on the next clk edge (1-cycle latency).
- Minimum spacing between we pulses: 40 bit-times (4 × 10).
- A new start edge arriving during STOP after the sample is accepted; back-to-back frames have no dead time.
- frame_err and loaded clear only on rst.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter counts bit-times (16 ticks each) while FSM=IDLE and byte index≠0.
  - When the counter reaches TIMEOUT_BITS, the byte index is cleared, the partial word is dropped, and hold falls on the next cycle.
  - The counter resets on every start edge.
- Not defined: a partial word persists indefinitely until completed or until reset. No counter logic is synthesised.

## Structure
- Package loader_pkg: the rx state enum (IDLE, START, DATA, STOP), the OVERSAMPLE=16 constant, and the MID_SAMPLE=8 constant.
- Sub-module uart_rx_byte contains the synchroniser, tick generator, and receive FSM. Its outputs are byte_valid (pulse), byte_data[7:0], frame_err_pulse and busy.
- The top module contains word assembly, address counter, hold/loaded/frame_err flags and the optional timeout.

## Test plan
All scenarios use CLK_FREQ=1_600_000 and BAUD=10_000, giving divisor 10 and 160 clk per bit.
- Send 0x12, 0x34, 0x56, 0x78 → exactly one we pulse with wa=0 and wd=0x12345678. wa=1 afterwards; loaded=1; hold=0.
- Drive rxd low for 30 clk, then high → no byte, FSM returns to IDLE, frame_err=0, no we.
- Send 0xAA, then 0xBB with stop bit low, then 0x01, 0x02, 0x03, 0x04 → frame_err=1 and the first two bytes are discarded. Single write: wa=0, wd=0x01020304.
- With ADDR_W=2, send 5 words (0x00000000 … 0x00000004) → writes at wa 0, 1, 2, 3, 0. The fifth write has wd=0x00000004.
- Send 0xDE, 0xAD, pulse rst low for 1 clk, then send 0xCA, 0xFE, 0xBA, 0xBE → only one write: wa=0, wd=0xCAFEBABE. hold=0 in the cycle after reset.
- With LOADER_TIMEOUT_EN and TIMEOUT_BITS=20: send 0x11, 0x22, idle for 30 bit-times, then send 0x33, 0x44, 0x55, 0x66 → hold drops after the timeout. Single write: wd=0x33445566.
